// File: rtl/spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// spi_master_arbiter
//
// Two-requester round-robin front end for an SPI-attached RAM. A granted
// request is turned into two SPI frames:
//   write: cmd 00 {addr}, then cmd 01 {wdata}
//   read : cmd 10 {addr}, then cmd 11 {8'h00}, followed by MISO_WAIT turnaround
//          cycles and 8 MISO samples (MSB first) that form rdata.
// Each frame shifts {cmd[1], cmd[1:0], payload[7:0]} MSB first while SS_n is low,
// and SS_n stays high for at least GAP cycles between and after frames.
//
// Handshake: req[i] is a level held by requester i. In IDLE the arbiter picks
// one requester; on that edge its op/addr/wdata are latched and ack[i] pulses
// for the following cycle. done[i] pulses once when the transaction ends
// (rdata is valid alongside done of a read). A request that is still high
// after done is treated as a new transaction.
//
// Parameters:
//   MISO_WAIT  idle SS_n-low cycles between last MOSI bit and first MISO sample
//   GAP        minimum SS_n-high cycles between frames
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req[1:0], op[1:0]   request levels and operations (0 write, 1 read)
//   addr0/1, wdata0/1   per-requester address and write data
//   ack[1:0], done[1:0] one-cycle accept / completion pulses
//   rdata[7:0]          read result
//   busy                high from ack through DONE
//   SS_n, MOSI, MISO    SPI bus
//   dbg_state[2:0]      current FSM state (IDLE=0 SHIFT=1 TURN=2 CAPTURE=3
//                       GAP=4 DONE=5)
// -----------------------------------------------------------------------------
module spi_master_arbiter #(
    parameter int MISO_WAIT = 2,
    parameter int GAP       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] op,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] ack,
    output logic [1:0] done,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic [2:0] dbg_state
);

    // A zero GAP would let two frames merge into one SS_n-low run.
    localparam int GAPL = (GAP < 1) ? 1 : GAP;
    localparam int CMAX = (MISO_WAIT > GAPL) ? ((MISO_WAIT > 10) ? MISO_WAIT : 10)
                                            : ((GAPL > 10) ? GAPL : 10);
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_TURN    = 3'd2,
        S_CAPTURE = 3'd3,
        S_GAP     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        state;
    logic          last;      // requester served most recently
    logic          sel;       // requester being served
    logic          op_q;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic          frame;     // 0: first frame, 1: second frame
    logic [CW-1:0] cnt;
    logic [9:0]    sh;        // MOSI bits still to be sent in this frame
    logic [7:0]    rx_sh;

    // 11-bit MOSI sequence: cmd[1] is sent twice (frame cycle 0 and as word MSB).
    function automatic logic [10:0] frame_seq(input logic rd, input logic second,
                                              input logic [7:0] a, input logic [7:0] w);
        logic [7:0] payload;
        payload = second ? (rd ? 8'h00 : w) : a;
        return {rd, rd, second, payload};
    endfunction

    logic        grant_v;
    logic        grant_id;
    logic        g_op;
    logic [7:0]  g_addr;
    logic [7:0]  g_wdata;
    logic [10:0] g_seq;
    logic [10:0] f2_seq;

    // Round robin: when both request, serve the one not served last. The
    // pointer resets to 1 so requester 0 wins the first contest.
    always_comb begin
        grant_v  = |req;
        grant_id = 1'b0;
        if (req == 2'b11) begin
            grant_id = ~last;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
        g_op    = grant_id ? op[1]  : op[0];
        g_addr  = grant_id ? addr1  : addr0;
        g_wdata = grant_id ? wdata1 : wdata0;
        g_seq   = frame_seq(g_op, 1'b0, g_addr, g_wdata);
        f2_seq  = frame_seq(op_q, 1'b1, addr_q, wdata_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            last    <= 1'b1;
            sel     <= 1'b0;
            op_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            frame   <= 1'b0;
            cnt     <= '0;
            sh      <= 10'h000;
            rx_sh   <= 8'h00;
            ack     <= 2'b00;
            done    <= 2'b00;
            rdata   <= 8'h00;
            busy    <= 1'b0;
            SS_n    <= 1'b1;
            MOSI    <= 1'b0;
        end else begin
            ack  <= 2'b00;
            done <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (grant_v) begin
                        ack     <= grant_id ? 2'b10 : 2'b01;
                        last    <= grant_id;
                        sel     <= grant_id;
                        op_q    <= g_op;
                        addr_q  <= g_addr;
                        wdata_q <= g_wdata;
                        busy    <= 1'b1;
                        frame   <= 1'b0;
                        cnt     <= '0;
                        // The ack cycle is already frame cycle 0.
                        SS_n    <= 1'b0;
                        MOSI    <= g_seq[10];
                        sh      <= g_seq[9:0];
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt == CW'(10)) begin
                        cnt  <= '0;
                        MOSI <= 1'b0;
                        if (op_q && frame) begin
                            // cmd 11: SS_n stays low for turnaround + capture.
                            state <= (MISO_WAIT > 0) ? S_TURN : S_CAPTURE;
                        end else begin
                            SS_n  <= 1'b1;
                            state <= S_GAP;
                        end
                    end else begin
                        MOSI <= sh[9];
                        sh   <= {sh[8:0], 1'b0};
                        cnt  <= cnt + CW'(1);
                    end
                end
                S_TURN: begin
                    if (cnt == CW'(MISO_WAIT - 1)) begin
                        cnt   <= '0;
                        state <= S_CAPTURE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_CAPTURE: begin
                    rx_sh <= {rx_sh[6:0], MISO};
                    if (cnt == CW'(7)) begin
                        cnt   <= '0;
                        SS_n  <= 1'b1;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == CW'(GAPL - 1)) begin
                        cnt <= '0;
                        if (!frame) begin
                            frame <= 1'b1;
                            SS_n  <= 1'b0;
                            MOSI  <= f2_seq[10];
                            sh    <= f2_seq[9:0];
                            state <= S_SHIFT;
                        end else begin
                            done <= sel ? 2'b10 : 2'b01;
                            if (op_q) begin
                                rdata <= rx_sh;
                            end
                            state <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_master_arbiter
//
// Directed bench for spi_master_arbiter. A cycle recorder (capture) observes
// the bus on falling edges, logs ack/done events and SS_n-low frames, plays
// the SPI slave (returns slave_byte on MISO during the capture window of a
// cmd 11 frame) and optionally drops acked requests or pulses req[0]. Each
// test task then compares the log against hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_master_arbiter;

    localparam int MW = 2;
    localparam int GP = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] op;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic [1:0] ack, done;
    logic [7:0] rdata;
    logic       busy, SS_n, MOSI, MISO;
    logic [2:0] dbg_state;

    spi_master_arbiter #(.MISO_WAIT(MW), .GAP(GP)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .done(done), .rdata(rdata), .busy(busy),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int         ack_cyc_q[$];
    logic [1:0] ack_val_q[$];
    int         done_cyc_q[$];
    logic [1:0] done_val_q[$];
    logic [7:0] done_rd_q[$];
    int         fr_start_q[$];
    int         fr_len_q[$];
    logic [10:0] fr_bits_q[$];
    int         busy_err, mosi_err, ack_both;
    logic [7:0] slave_byte;
    logic [1:0] exp_q[$];

    task automatic apply_reset();
        rst = 1'b1; req = 2'b00; MISO = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycle c = c-th falling edge after the call.
    task automatic capture(input int ncyc, input bit auto_drop, input int pulse_cyc);
        bit in_txn, in_frame, rd_frame;
        int k, start, j;
        logic [10:0] bits;
        ack_cyc_q.delete(); ack_val_q.delete();
        done_cyc_q.delete(); done_val_q.delete(); done_rd_q.delete();
        fr_start_q.delete(); fr_len_q.delete(); fr_bits_q.delete();
        busy_err = 0; mosi_err = 0; ack_both = 0;
        in_txn = 0; in_frame = 0; rd_frame = 0; k = 0; start = 0; bits = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                ack_cyc_q.push_back(c);
                ack_val_q.push_back(ack);
                if (ack === 2'b11) ack_both++;
                in_txn = 1;
            end
            if (busy !== in_txn) busy_err++;
            if (done !== 2'b00) begin
                done_cyc_q.push_back(c);
                done_val_q.push_back(done);
                done_rd_q.push_back(rdata);
                in_txn = 0;
            end
            if (auto_drop) req = req & ~ack;
            if (SS_n === 1'b1) begin
                if (MOSI !== 1'b0) mosi_err++;
                if (in_frame) begin
                    fr_start_q.push_back(start);
                    fr_len_q.push_back(k);
                    fr_bits_q.push_back(bits);
                    in_frame = 0;
                end
                MISO = 1'b0;
            end else begin
                if (!in_frame) begin
                    in_frame = 1; k = 0; start = c; bits = '0; rd_frame = 0;
                end
                if (k < 11) bits = {bits[9:0], MOSI};
                if (k == 2) rd_frame = (bits[1:0] == 2'b11);
                j = k - 11 - MW;
                if (rd_frame && j >= 0 && j < 8) MISO = slave_byte[7-j];
                else MISO = 1'b0;
                k++;
            end
            if (pulse_cyc >= 0) begin
                if (c == pulse_cyc) req[0] = 1'b1;
                else if (c == pulse_cyc + 1) req[0] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (SS_n !== 1'b1) begin n_err++; $display("FAIL reset_ss_n: got %b want 1", SS_n); end
        n_vec++; if (MOSI !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
        n_vec++; if (ack !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b want 00", ack); end
        n_vec++; if (done !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b want 00", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_vec++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        apply_reset();
    endtask

    task automatic test_write();
        logic [10:0] e0, e1;
        e0 = 11'b0_0000010010;
        e1 = 11'b0_0110100101;
        @(negedge clk);
        req = 2'b01; op = 2'b00; addr0 = 8'h12; wdata0 = 8'hA5;
        capture(40, 1'b1, -1);
        n_vec++;
        if (ack_cyc_q.size() != 1 || fr_bits_q.size() != 2 || done_cyc_q.size() != 1) begin
            n_err++;
            $display("FAIL write_counts: acks %0d frames %0d dones %0d, want 1 2 1",
                     ack_cyc_q.size(), fr_bits_q.size(), done_cyc_q.size());
        end else begin
            n_vec++; if (ack_cyc_q[0] != 0 || ack_val_q[0] !== 2'b01) begin n_err++; $display("FAIL write_ack: cyc %0d val %b, want 0 01", ack_cyc_q[0], ack_val_q[0]); end
            n_vec++; if (fr_bits_q[0] !== e0) begin n_err++; $display("FAIL write_frame0: got %b want %b", fr_bits_q[0], e0); end
            n_vec++; if (fr_bits_q[1] !== e1) begin n_err++; $display("FAIL write_frame1: got %b want %b", fr_bits_q[1], e1); end
            n_vec++; if (fr_len_q[0] != 11 || fr_len_q[1] != 11) begin n_err++; $display("FAIL write_len: got %0d/%0d want 11/11", fr_len_q[0], fr_len_q[1]); end
            n_vec++; if (fr_start_q[1] - (fr_start_q[0] + fr_len_q[0]) != GP) begin n_err++; $display("FAIL write_gap: got %0d want %0d", fr_start_q[1] - (fr_start_q[0] + fr_len_q[0]), GP); end
            n_vec++; if (done_cyc_q[0] != 24 || done_val_q[0] !== 2'b01) begin n_err++; $display("FAIL write_done: cyc %0d val %b, want 24 01", done_cyc_q[0], done_val_q[0]); end
        end
        n_vec++; if (busy_err != 0) begin n_err++; $display("FAIL write_busy: %0d bad cycles, want 0", busy_err); end
        n_vec++; if (mosi_err != 0) begin n_err++; $display("FAIL write_mosi_idle: %0d bad cycles, want 0", mosi_err); end
    endtask

    task automatic test_read();
        logic [10:0] e0, e1;
        e0 = 11'b1_1001000000;
        e1 = 11'b1_1100000000;
        slave_byte = 8'h3C;
        @(negedge clk);
        req = 2'b10; op = 2'b10; addr1 = 8'h40; wdata1 = 8'hFF;
        capture(40, 1'b1, -1);
        n_vec++;
        if (fr_bits_q.size() != 2 || done_cyc_q.size() != 1) begin
            n_err++;
            $display("FAIL read_counts: frames %0d dones %0d, want 2 1", fr_bits_q.size(), done_cyc_q.size());
        end else begin
            n_vec++; if (fr_bits_q[0] !== e0) begin n_err++; $display("FAIL read_frame0: got %b want %b", fr_bits_q[0], e0); end
            n_vec++; if (fr_bits_q[1] !== e1) begin n_err++; $display("FAIL read_frame1: got %b want %b", fr_bits_q[1], e1); end
            n_vec++; if (fr_len_q[0] != 11 || fr_len_q[1] != 21) begin n_err++; $display("FAIL read_len: got %0d/%0d want 11/21", fr_len_q[0], fr_len_q[1]); end
            n_vec++; if (done_cyc_q[0] != 34 || done_val_q[0] !== 2'b10) begin n_err++; $display("FAIL read_done: cyc %0d val %b, want 34 10", done_cyc_q[0], done_val_q[0]); end
            n_vec++; if (done_rd_q[0] !== 8'h3C) begin n_err++; $display("FAIL read_rdata: got %h want 3C", done_rd_q[0]); end
        end
        n_vec++; if (busy_err != 0) begin n_err++; $display("FAIL read_busy: %0d bad cycles, want 0", busy_err); end
        // A following write must leave rdata untouched.
        @(negedge clk);
        req = 2'b01; op = 2'b00; addr0 = 8'h5A; wdata0 = 8'hC3;
        capture(30, 1'b1, -1);
        n_vec++;
        if (done_cyc_q.size() != 1) begin
            n_err++; $display("FAIL hold_count: dones %0d want 1", done_cyc_q.size());
        end else begin
            n_vec++; if (done_val_q[0] !== 2'b01 || done_rd_q[0] !== 8'h3C) begin n_err++; $display("FAIL hold_rdata: done %b rdata %h, want 01 3C", done_val_q[0], done_rd_q[0]); end
        end
    endtask

    task automatic test_round_robin();
        logic [10:0] e_r1;
        logic [1:0]  e;
        e_r1 = 11'b0_0000110011;
        apply_reset();
        exp_q.delete();
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        req = 2'b11; op = 2'b00;
        addr0 = 8'h11; wdata0 = 8'h22; addr1 = 8'h33; wdata1 = 8'h44;
        capture(110, 1'b0, -1);
        n_vec++;
        if (ack_val_q.size() < 4 || done_val_q.size() < 4 || fr_bits_q.size() < 3) begin
            n_err++;
            $display("FAIL rr_counts: acks %0d dones %0d frames %0d, want >=4 >=4 >=3",
                     ack_val_q.size(), done_val_q.size(), fr_bits_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = exp_q.pop_front();
                n_vec++; if (ack_val_q[i] !== e) begin n_err++; $display("FAIL rr_ack%0d: got %b want %b", i, ack_val_q[i], e); end
                n_vec++; if (done_val_q[i] !== e) begin n_err++; $display("FAIL rr_done%0d: got %b want %b", i, done_val_q[i], e); end
            end
            n_vec++; if (fr_bits_q[2] !== e_r1) begin n_err++; $display("FAIL rr_frame_req1: got %b want %b", fr_bits_q[2], e_r1); end
        end
        n_vec++; if (ack_both != 0) begin n_err++; $display("FAIL rr_ack_both: %0d cycles, want 0", ack_both); end
        req = 2'b00;
    endtask

    task automatic test_ignore_pulse();
        apply_reset();
        slave_byte = 8'h96;
        req = 2'b10; op = 2'b10; addr1 = 8'h40;
        capture(40, 1'b1, 5);
        n_vec++;
        if (ack_val_q.size() != 1 || done_val_q.size() != 1) begin
            n_err++; $display("FAIL pulse_counts: acks %0d dones %0d, want 1 1", ack_val_q.size(), done_val_q.size());
        end else begin
            n_vec++; if (ack_val_q[0] !== 2'b10 || done_val_q[0] !== 2'b10) begin n_err++; $display("FAIL pulse_owner: ack %b done %b, want 10 10", ack_val_q[0], done_val_q[0]); end
            n_vec++; if (done_rd_q[0] !== 8'h96) begin n_err++; $display("FAIL pulse_rdata: got %h want 96", done_rd_q[0]); end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req = 2'b01; op = 2'b00; addr0 = 8'h01; wdata0 = 8'h80;
        capture(60, 1'b0, -1);
        n_vec++;
        if (ack_cyc_q.size() < 2 || done_cyc_q.size() < 1 || fr_start_q.size() < 3) begin
            n_err++; $display("FAIL b2b_counts: acks %0d dones %0d frames %0d, want >=2 >=1 >=3",
                              ack_cyc_q.size(), done_cyc_q.size(), fr_start_q.size());
        end else begin
            n_vec++; if (done_cyc_q[0] != 24 || ack_cyc_q[1] != 26) begin n_err++; $display("FAIL b2b_timing: done %0d ack2 %0d, want 24 26", done_cyc_q[0], ack_cyc_q[1]); end
            n_vec++; if (ack_val_q[1] !== 2'b01) begin n_err++; $display("FAIL b2b_ack2: got %b want 01", ack_val_q[1]); end
            n_vec++; if (fr_start_q[2] - (fr_start_q[1] + fr_len_q[1]) < GP) begin n_err++; $display("FAIL b2b_gap: got %0d want >=%0d", fr_start_q[2] - (fr_start_q[1] + fr_len_q[1]), GP); end
        end
        n_vec++; if (busy_err != 0) begin n_err++; $display("FAIL b2b_busy: %0d bad cycles, want 0", busy_err); end
        req = 2'b00;
    endtask

    task automatic test_reset_mid();
        bit got;
        apply_reset();
        @(negedge clk);
        req = 2'b01; op = 2'b00; addr0 = 8'h20; wdata0 = 8'h00;
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (ack === 2'b01) got = 1;
        end
        req = 2'b00;
        n_vec++; if (!got) begin n_err++; $display("FAIL rmid_ack: no ack within 5 cycles"); end
        repeat (5) @(negedge clk);
        n_vec++; if (SS_n !== 1'b0 || MOSI !== 1'b1) begin n_err++; $display("FAIL rmid_pre: SS_n %b MOSI %b, want 0 1", SS_n, MOSI); end
        rst = 1'b1;
        #1;
        n_vec++; if (SS_n !== 1'b1 || MOSI !== 1'b0) begin n_err++; $display("FAIL rmid_bus: SS_n %b MOSI %b, want 1 0", SS_n, MOSI); end
        n_vec++; if (busy !== 1'b0 || done !== 2'b00 || dbg_state !== 3'd0) begin n_err++; $display("FAIL rmid_ctl: busy %b done %b state %0d, want 0 00 0", busy, done, dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        capture(40, 1'b1, -1);
        n_vec++; if (ack_cyc_q.size() != 0 || done_cyc_q.size() != 0 || fr_start_q.size() != 0) begin n_err++; $display("FAIL rmid_after: acks %0d dones %0d frames %0d, want 0 0 0", ack_cyc_q.size(), done_cyc_q.size(), fr_start_q.size()); end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; op = 2'b00; MISO = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        slave_byte = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_ignore_pulse();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 SHALL have parameters (one per line: name, default, meaning):
- MISO_WAIT, 2, idle cycles between last MOSI bit and first MISO sample in a read-data frame
- GAP, 1, minimum SS_n-high cycles between frames
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  2  per-requester request level, held until ack
- op  in  2  per-requester operation: 0 write, 1 read
- addr0, addr1  in  8  RAM address per requester
- wdata0, wdata1  in  8  write data per requester
- ack  out  2  one-cycle pulse: request accepted, inputs latched
- done  out  2  one-cycle pulse: transaction complete
- rdata  out  8  read result, valid with done of a read
- busy  out  1  transaction in progress
- SS_n  out  1  SPI slave select, active-low
- MOSI  out  1  SPI serial data to slave
- MISO  in  1  SPI serial data from slave
REQ-003 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-004 SHALL arbitrate round-robin: single request granted directly; on both requesting, grant requester not served last; pointer after reset favours requester 0.
REQ-005 SHALL only grant from IDLE; ack pulses the cycle after grant decision, with op/addr/wdata latched that same edge.
REQ-006 SHALL map write to two frames: cmd 00 {addr}, then cmd 01 {wdata}; read to two frames: cmd 10 {addr}, then cmd 11 {8'h00}.
REQ-007 SHALL form each frame word as {cmd[1:0], payload[7:0]}, 10 bits.
REQ-008 Frame timing SHALL be: SS_n low; frame cycle 0 MOSI = cmd[1]; cycles 1..10 MOSI = word[9]..word[0], MSB first.
REQ-009 For cmd 11 SHALL keep SS_n low for MISO_WAIT further cycles, then sample MISO on 8 consecutive edges into rdata MSB first.
REQ-010 SHALL hold SS_n high at least GAP cycles between frames and after the final frame.
REQ-011 State machine SHALL be IDLE -> SHIFT -> (cmd 11: TURN -> CAPTURE) -> GAP -> SHIFT (second frame) or DONE -> IDLE.
REQ-012 done[i] SHALL pulse in DONE for granted requester i only; rdata updates only on reads, held otherwise.
REQ-013 busy SHALL be 1 from ack through DONE inclusive, 0 in IDLE.
REQ-014 MOSI SHALL be 0 whenever SS_n is high.
REQ-015 Request dropped before ack SHALL be ignored; request held through done SHALL be re-arbitrated in IDLE as new transaction.
REQ-016 Frame length SHALL be exactly 11 SS_n-low cycles for cmd 00/01/10 and 11+MISO_WAIT+8 for cmd 11; bit counter SHALL not wrap mid-frame.

Reset
REQ-017 rst asserted SHALL immediately force SS_n=1, MOSI=0, ack=0, done=0, busy=0, rdata=8'h00, state IDLE, pointer to requester 0.
REQ-018 rst mid-transaction SHALL abort it with no done pulse; the requester must re-request.
REQ-019 First grant SHALL occur no earlier than first rising clk after rst deasserts.

Verification
REQ-020 Write req0 addr 8'h12 wdata 8'hA5 -> MOSI frames 0_0000010010 and 0_0110100101 (cmd bit then word), 11 low cycles each, GAP high between, done[0] once.
REQ-021 Read req1 addr 8'h40, slave MISO returns 8'h3C -> frames cmd 10/11, SS_n low 21 cycles for second frame, rdata=8'h3C with done[1].
REQ-022 req=2'b11 from reset held -> grant order 0,1,0,1; ack never both bits same cycle.
REQ-023 rst asserted at frame cycle 5 of first frame -> SS_n=1, MOSI=0 same cycle, no done, busy=0.
REQ-024 req0 pulsed one cycle while busy serving req1 -> ignored, no ack[0].
REQ-025 Back-to-back writes from req0 held -> second ack only after first done, SS_n high ≥GAP between transactions.
